// File: rtl/rcv_pkg.sv
// ---------------------------------------------------------------------------
// rcv_pkg
// Shared types and sizing helpers for the framed serial receiver.
//   state_t     : receiver FSM states.
//   timerWidth  : bits needed for a counter that runs 0 .. bitPeriod-1.
//   countWidth  : bits needed to count 0 .. numBits data samples.
// ---------------------------------------------------------------------------
package rcv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        LOAD  = 3'd4
    } state_t;

    function automatic int timerWidth(input int bitPeriod);
        return (bitPeriod > 2) ? $clog2(bitPeriod) : 1;
    endfunction

    function automatic int countWidth(input int numBits);
        return (numBits > 1) ? $clog2(numBits + 1) : 1;
    endfunction

endpackage

// File: rtl/flex_stp_sr.sv
// ---------------------------------------------------------------------------
// flex_stp_sr
// Parameterized serial-to-parallel shift register.
//   clk          : system clock, rising edge
//   n_rst        : asynchronous active-low reset (register -> all 1s)
//   shift_enable : shift one bit in this cycle
//   serial_in    : bit to shift in
//   parallel_out : current register contents
// SHIFT_MSB=0 : the first bit shifted in ends up in bit 0 (shift right).
// SHIFT_MSB=1 : the first bit shifted in ends up in the MSB (shift left).
// ---------------------------------------------------------------------------
module flex_stp_sr #(
    parameter int NUM_BITS  = 8,
    parameter bit SHIFT_MSB = 1'b0
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                shift_enable,
    input  logic                serial_in,
    output logic [NUM_BITS-1:0] parallel_out
);

    logic [NUM_BITS-1:0] shiftReg_q;
    logic [NUM_BITS-1:0] shiftReg_d;

    // Next value: new bit enters at the end that drains toward its final slot.
    always_comb begin
        shiftReg_d = shiftReg_q;
        if (shift_enable) begin
            if (SHIFT_MSB) begin
                shiftReg_d = {shiftReg_q[NUM_BITS-2:0], serial_in};
            end else begin
                shiftReg_d = {serial_in, shiftReg_q[NUM_BITS-1:1]};
            end
        end
    end

    // Register resets to all 1s, matching an idle-high line.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shiftReg_q <= '1;
        end else begin
            shiftReg_q <= shiftReg_d;
        end
    end

    assign parallel_out = shiftReg_q;

endmodule

// File: rtl/flex_stp_rcv.sv
// ---------------------------------------------------------------------------
// flex_stp_rcv
// Framed serial receiver: idle-high line, start bit 0, NUM_DATA_BITS data
// bits, one stop bit 1. Delivers a parallel word with a ready/read handshake.
//   clk           : system clock, rising edge
//   n_rst         : asynchronous active-low reset
//   serial_in     : asynchronous serial line, idle high
//   data_read     : consumer pulse acknowledging rx_data
//   rx_data       : data of the last good frame
//   data_ready    : rx_data holds unread data
//   overrun_error : an unread word was overwritten
//   framing_error : the last frame's stop bit was 0
// ---------------------------------------------------------------------------
module flex_stp_rcv
    import rcv_pkg::*;
#(
    parameter int NUM_DATA_BITS = 8,
    parameter int BIT_PERIOD    = 10,
    parameter bit SHIFT_MSB     = 1'b0
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     serial_in,
    input  logic                     data_read,
    output logic [NUM_DATA_BITS-1:0] rx_data,
    output logic                     data_ready,
    output logic                     overrun_error,
    output logic                     framing_error
);

    localparam int TW = timerWidth(BIT_PERIOD);
    localparam int CW = countWidth(NUM_DATA_BITS);
    localparam logic [TW-1:0] HALF_LAST = TW'(BIT_PERIOD / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_PERIOD - 1);
    localparam logic [CW-1:0] LAST_BIT  = CW'(NUM_DATA_BITS - 1);

    logic   sync1_q, sync2_q, prev_q;
    state_t state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] count_q, count_d;
    logic   stop_q, stop_d;
    logic [NUM_DATA_BITS-1:0] rx_q, rx_d;
    logic   ready_q, ready_d;
    logic   ovr_q, ovr_d;
    logic   frm_q, frm_d;
    logic   shiftEn;
    logic   startDetect;
    logic [NUM_DATA_BITS-1:0] shiftWord;

    // Two-flop synchronizer plus a third flop holding the previous synced
    // value; all reset high so a line that is idle at release is not a start.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign startDetect = prev_q & ~sync2_q;

    // Next-state logic. The timer restarts at every sample point so the
    // first sample lands mid start bit and later ones one bit period apart.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        count_d = count_q;
        stop_d  = stop_q;
        shiftEn = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                count_d = '0;
                if (startDetect) state_d = START;
            end
            START: begin
                if (timer_q == HALF_LAST) begin
                    timer_d = '0;
                    state_d = sync2_q ? IDLE : DATA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DATA: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    shiftEn = 1'b1;
                    if (count_q == LAST_BIT) begin
                        count_d = '0;
                        state_d = STOP;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            STOP: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    stop_d  = sync2_q;
                    state_d = LOAD;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            LOAD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register updates. A good load takes priority over a read in the
    // same cycle, so the fresh word is never lost to a late acknowledge.
    always_comb begin
        rx_d    = rx_q;
        ready_d = ready_q;
        ovr_d   = ovr_q;
        frm_d   = frm_q;
        if (state_q == LOAD) begin
            if (stop_q) begin
                rx_d    = shiftWord;
                ready_d = 1'b1;
                frm_d   = 1'b0;
                ovr_d   = ovr_q | (ready_q & ~data_read);
            end else begin
                frm_d = 1'b1;
            end
        end else if (data_read) begin
            ready_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    // FSM, timer, counters and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            count_q <= '0;
            stop_q  <= 1'b0;
            rx_q    <= '1;
            ready_q <= 1'b0;
            ovr_q   <= 1'b0;
            frm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            count_q <= count_d;
            stop_q  <= stop_d;
            rx_q    <= rx_d;
            ready_q <= ready_d;
            ovr_q   <= ovr_d;
            frm_q   <= frm_d;
        end
    end

    flex_stp_sr #(
        .NUM_BITS  (NUM_DATA_BITS),
        .SHIFT_MSB (SHIFT_MSB)
    ) uShifter (
        .clk          (clk),
        .n_rst        (n_rst),
        .shift_enable (shiftEn),
        .serial_in    (sync2_q),
        .parallel_out (shiftWord)
    );

    assign rx_data       = rx_q;
    assign data_ready    = ready_q;
    assign overrun_error = ovr_q;
    assign framing_error = frm_q;

endmodule

// File: tb/tb_flex_stp_rcv.sv
module tb_flex_stp_rcv;

    typedef struct {
        logic [7:0] data;
        logic       ready;
        logic       ovr;
        logic       frm;
    } expect_t;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       sin0 = 1'b1, sin1 = 1'b1;
    logic       rd0 = 1'b0, rd1 = 1'b0;
    logic [7:0] rx0, rx1;
    logic       rdy0, rdy1, ovr0, ovr1, frm0, frm1;

    int checks = 0;
    int failures = 0;

    expect_t    scoreboard[$];
    logic [7:0] expData[2];
    logic       expReady[2];
    logic       expOvr[2];
    logic       expFrm[2];

    always #5 clk = ~clk;

    flex_stp_rcv #(.NUM_DATA_BITS(8), .BIT_PERIOD(10), .SHIFT_MSB(1'b0)) dutLsb (
        .clk(clk), .n_rst(n_rst), .serial_in(sin0), .data_read(rd0),
        .rx_data(rx0), .data_ready(rdy0), .overrun_error(ovr0), .framing_error(frm0)
    );

    flex_stp_rcv #(.NUM_DATA_BITS(8), .BIT_PERIOD(10), .SHIFT_MSB(1'b1)) dutMsb (
        .clk(clk), .n_rst(n_rst), .serial_in(sin1), .data_read(rd1),
        .rx_data(rx1), .data_ready(rdy1), .overrun_error(ovr1), .framing_error(frm1)
    );

    // One comparison: count it, and on mismatch count and report it.
    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setLine(input int w, input logic v);
        if (w == 0) sin0 = v; else sin1 = v;
    endtask

    task automatic setRead(input int w, input logic v);
        if (w == 0) rd0 = v; else rd1 = v;
    endtask

    task automatic sampleOutputs(input int w, output logic [7:0] d, output logic r,
                                 output logic o, output logic f);
        if (w == 0) begin d = rx0; r = rdy0; o = ovr0; f = frm0; end
        else        begin d = rx1; r = rdy1; o = ovr1; f = frm1; end
    endtask

    // Compare all four outputs of one receiver against its model.
    task automatic checkModel(input int w, input string tag);
        logic [7:0] d; logic r, o, f;
        sampleOutputs(w, d, r, o, f);
        checkOutput($sformatf("%s.rxData[%0d]", tag, w), {8'h0, d}, {8'h0, expData[w]});
        checkOutput($sformatf("%s.dataReady[%0d]", tag, w), {15'h0, r}, {15'h0, expReady[w]});
        checkOutput($sformatf("%s.overrun[%0d]", tag, w), {15'h0, o}, {15'h0, expOvr[w]});
        checkOutput($sformatf("%s.framing[%0d]", tag, w), {15'h0, f}, {15'h0, expFrm[w]});
    endtask

    task automatic resetModel();
        for (int i = 0; i < 2; i++) begin
            expData[i] = 8'hFF; expReady[i] = 1'b0; expOvr[i] = 1'b0; expFrm[i] = 1'b0;
        end
    endtask

    // Send one frame on receiver w, starting at a falling clock edge. Edge k
    // is the first rising edge to see the start bit; outputs must be
    // unchanged after edge k+97 and updated after edge k+98.
    task automatic applyStimulus(input int w, input logic [7:0] d, input logic stopBit,
                                 input logic readInLoad, input string tag);
        logic [9:0] frameBits;
        expect_t    e, got;
        logic [7:0] od; logic orr, oo, of;
        logic [7:0] oldData;
        frameBits[0] = 1'b0;
        for (int i = 0; i < 8; i++) frameBits[i+1] = (w == 1) ? d[7-i] : d[i];
        frameBits[9] = stopBit;
        oldData = expData[w];
        e.data = expData[w]; e.ready = expReady[w]; e.ovr = expOvr[w]; e.frm = expFrm[w];
        if (stopBit) begin
            e.ovr   = expOvr[w] | (expReady[w] & ~readInLoad);
            e.data  = d;
            e.ready = 1'b1;
            e.frm   = 1'b0;
        end else begin
            e.frm = 1'b1;
        end
        scoreboard.push_back(e);
        for (int j = 0; j < 100; j++) begin
            setLine(w, frameBits[j / 10]);
            @(negedge clk);
            if (j == 97) begin
                sampleOutputs(w, od, orr, oo, of);
                checkOutput($sformatf("%s.latency[%0d]", tag, w), {8'h0, od}, {8'h0, oldData});
                if (readInLoad) setRead(w, 1'b1);
            end
            if (j == 98) begin
                setRead(w, 1'b0);
                got = scoreboard.pop_front();
                expData[w] = got.data; expReady[w] = got.ready;
                expOvr[w] = got.ovr; expFrm[w] = got.frm;
                checkModel(w, tag);
            end
        end
        setLine(w, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    // One-cycle read pulse; ready and overrun must clear on the next edge.
    task automatic readPulse(input int w, input string tag);
        setRead(w, 1'b1);
        @(negedge clk);
        setRead(w, 1'b0);
        expReady[w] = 1'b0;
        expOvr[w] = 1'b0;
        checkModel(w, tag);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        $display("[TB] start");
        resetModel();
        repeat (3) @(negedge clk);
        checkModel(0, "reset");
        checkModel(1, "reset");
        n_rst = 1'b1;
        repeat (4) @(negedge clk);

        // Framing error first, then a good frame clears it.
        applyStimulus(0, 8'h3C, 1'b0, 1'b0, "framing");
        applyStimulus(0, 8'h11, 1'b1, 1'b0, "afterFraming");
        readPulse(0, "read1");

        // Plain good frame.
        applyStimulus(0, 8'hA5, 1'b1, 1'b0, "goodA5");
        readPulse(0, "read2");

        // Overrun: two frames without a read.
        applyStimulus(0, 8'h55, 1'b1, 1'b0, "ovrFirst");
        applyStimulus(0, 8'hAA, 1'b1, 1'b0, "ovrSecond");
        readPulse(0, "ovrClear");

        // Read coincides with the load of the second frame.
        applyStimulus(0, 8'h33, 1'b1, 1'b0, "simFirst");
        applyStimulus(0, 8'h0F, 1'b1, 1'b1, "simLoad");
        readPulse(0, "read3");

        // Three-clock glitch must be rejected without touching outputs.
        sin0 = 1'b0;
        repeat (3) @(negedge clk);
        sin0 = 1'b1;
        repeat (20) @(negedge clk);
        checkModel(0, "falseStart");
        applyStimulus(0, 8'h81, 1'b1, 1'b0, "after81");

        // MSB-first receiver.
        applyStimulus(1, 8'hC3, 1'b1, 1'b0, "msbC3");

        // Reset in the middle of a frame on the MSB-first receiver.
        sin1 = 1'b0;
        repeat (30) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        resetModel();
        checkModel(0, "midReset");
        checkModel(1, "midReset");
        sin1 = 1'b1;
        @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        applyStimulus(1, 8'h7E, 1'b1, 1'b0, "msb7E");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flex_stp_rcv.md
Name: flex_stp_rcv

Overview:
- Framed serial receiver; the inverse of the team's parallel-to-serial shifter. Accepts an async, idle-high serial line (start 0, NUM_DATA_BITS data, one stop 1) and delivers a parallel word with data_ready/data_read handshake.
- Reports framing and overrun errors.
- Sits at the receive end of the serial link, feeding the packet/FIFO logic.

Parameters:
- NUM_DATA_BITS, 8, data bits per frame (2..16).
- BIT_PERIOD, 10, clocks per serial bit (even, >=4).
- SHIFT_MSB, 0, 0 = LSB arrives first, 1 = MSB arrives first.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- serial_in  input  1  async serial line, idle high.
- data_read  input  1  consumer pulse; acknowledges rx_data.
- rx_data  output  NUM_DATA_BITS  last good frame's data.
- data_ready  output  1  rx_data holds unread data.
- overrun_error  output  1  unread word was overwritten.
- framing_error  output  1  last frame's stop bit was 0.

Behaviour:
- Reset (async, n_rst=0): rx_data = all 1s, data_ready = 0, overrun_error = 0, framing_error = 0, FSM = IDLE, sync flops = 1, timer and bit count = 0.
- serial_in passes through a 2-flop synchronizer. Start detect is synced=0 while previous synced=1.
- FSM states: IDLE, START, DATA, STOP, LOAD.
- IDLE -> START on start detect. This edge is 2 clocks after the first edge sampling serial_in=0.
- START: timer counts to BIT_PERIOD/2 and samples the line.
  - Sample 1: false start, -> IDLE. No outputs change.
  - Sample 0: -> DATA.
- DATA: samples every BIT_PERIOD clocks, shifting into the sub-shifter. Bit i is sampled at BIT_PERIOD/2 + (i+1)*BIT_PERIOD after entering START. -> STOP after NUM_DATA_BITS samples.
- STOP: samples the stop bit BIT_PERIOD later, -> LOAD.
- LOAD (1 cycle), outputs registered on the exit edge, then -> IDLE:
  - stop=1: rx_data <= shifted word, data_ready <= 1, framing_error <= 0. overrun_error <= 1 if data_ready was 1 and data_read=0 this cycle.
  - stop=0: framing_error <= 1. rx_data, data_ready and overrun_error are unchanged.
- Latency: outputs update on edge k+2+BIT_PERIOD/2+(NUM_DATA_BITS+1)*BIT_PERIOD+1, where k is the edge that first samples the start bit. Defaults give k+98.
- data_read=1 in any non-LOAD cycle clears data_ready and overrun_error on the next edge. It never clears framing_error.
- data_read and good LOAD in the same cycle: the load wins. data_ready stays 1, overrun_error is not set, and rx_data takes the new word.
- Back-to-back frames: a start edge is accepted in the IDLE cycle immediately after LOAD. No extra gap is required.
- Line glitches mid-frame do not restart the frame. Only scheduled sample points are used.
- SHIFT_MSB=0: bit i arriving i-th lands in rx_data[i]. SHIFT_MSB=1: the first bit lands in rx_data[NUM_DATA_BITS-1].
- Async reset mid-frame returns everything to reset values. After reset release, the next falling edge is a new start.

Decomposition:
- Package rcv_pkg:
  - state_t enum (IDLE, START, DATA, STOP, LOAD).
  - Timer-width and bit-count-width localparam helper functions ($clog2-based).
- Sub-module flex_stp_sr: parameterized serial-to-parallel shifter.
  - Ports: clk, n_rst, shift_enable, serial_in, parallel_out.
  - Parameters: NUM_BITS, SHIFT_MSB. Resets to all 1s.
  - Instantiated once with NUM_BITS = NUM_DATA_BITS.
- FSM, timer, synchronizer and output registers live in flex_stp_rcv.

Test Plan:
- Good frame: defaults, send 0xA5 LSB first (1,0,1,0,0,1,0,1), stop 1 -> data_ready rises at edge k+98, rx_data=0xA5, both errors 0.
- Framing error: send 0x3C with stop=0 -> framing_error=1, data_ready stays 0, rx_data stays 0xFF. Next good frame 0x11 -> rx_data=0x11, framing_error=0.
- Overrun: send 0x55 with no data_read, then 0xAA -> rx_data=0xAA, overrun_error=1. data_read pulse -> data_ready=0 and overrun_error=0 next edge.
- Simultaneous read/load: assert data_read in the LOAD cycle of the second frame 0x0F -> data_ready=1, overrun_error=0, rx_data=0x0F.
- False start: a 3-clock low glitch on idle line -> FSM returns to IDLE, no output change. A following good frame 0x81 is received correctly.
- MSB-first and reset: SHIFT_MSB=1, send 0xC3 -> rx_data=0xC3. Assert n_rst mid-frame -> all outputs at reset values immediately. A frame 0x7E after release is received correctly.
